// File: rtl/vga_scanout_reader.sv
// vga_scanout_reader: 640x480@60 (parameterisable) raster generator that
// fetches pixels sequentially from an 8-bit framebuffer and realigns the
// returned data with hsync/vsync/blank at the output pins.
module vga_scanout_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [18:0] fb_rd_addr,
  input  logic [7:0]  fb_rd_data,
  output logic [7:0]  pixel_out,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int D       = RD_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   addr_q, addr_d;
  logic          in_active;
  logic          act_raw, hs_raw, vs_raw, fs_raw;
  logic [D-1:0]  act_q, hs_q, vs_q, fs_q;
  logic [7:0]    pix_q, pix_d;

  // Stage-0 raw timing decoded from the counters; forced inactive when disabled
  always_comb begin
    in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    act_raw   = enable && in_active;
    hs_raw    = !(enable && (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs_raw    = !(enable && (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    fs_raw    = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Next-state for raster counters and the incremental fetch address
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      addr_d  = '0;
    end else begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      // Address always names the next pixel to fetch; it only moves on visible pixels
      if (in_active) begin
        addr_d = ((h_cnt_q == H_ACT_LAST) && (v_cnt_q == V_ACT_LAST)) ? '0 : addr_q + 19'd1;
      end
    end
  end

  // Data returned RD_LATENCY clocks after its address lines up with pipeline stage D-2
  always_comb begin
    pix_d = act_q[D-2] ? fb_rd_data : '0;
  end

  // Counter, address and alignment pipeline registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      act_q   <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      fs_q    <= '0;
      pix_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      act_q   <= {act_q[D-2:0], act_raw};
      hs_q    <= {hs_q[D-2:0], hs_raw};
      vs_q    <= {vs_q[D-2:0], vs_raw};
      fs_q    <= {fs_q[D-2:0], fs_raw};
      pix_q   <= pix_d;
    end
  end

  assign fb_rd_addr  = addr_q;
  assign pixel_out   = pix_q;
  assign blank_n     = act_q[D-1];
  assign hsync       = hs_q[D-1];
  assign vsync       = vs_q[D-1];
  assign frame_start = fs_q[D-1];

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: two reduced-timing instances (RD_LATENCY 1 and 3)
// against a raster model with an output scoreboard, plus a full 640x480 instance
// checked over the first two lines.
module tb_vga_scanout_reader;

  localparam int SHA = 12, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 4,  SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int DA = 2, DB = 4;

  typedef struct {
    logic [7:0] pix;
    logic       bn, hs, vs, fs;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [18:0] addr_a, addr_b, addr_c;
  logic [7:0]  data_a, data_c, pix_a, pix_b, pix_c;
  logic [7:0]  rpb [3];
  logic        hs_a, vs_a, bn_a, fs_a;
  logic        hs_b, vs_b, bn_b, fs_b;
  logic        hs_c, vs_c, bn_c, fs_c;

  int   checks = 0, errors = 0;
  int   mh = 0, mv = 0, cyc = 0;
  logic c_window = 1'b0;
  exp_t qa[$], qb[$];

  always #5 clock = ~clock;

  function automatic logic [7:0] ramf(input logic [18:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Framebuffer read-port models with 1 and 3 clocks of latency
  always @(posedge clock) begin
    data_a <= ramf(addr_a);
    data_c <= ramf(addr_c);
    rpb[0] <= ramf(addr_b);
    rpb[1] <= rpb[0];
    rpb[2] <= rpb[1];
  end

  vga_scanout_reader #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .RD_LATENCY(1)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .fb_rd_addr(addr_a),
    .fb_rd_data(data_a), .pixel_out(pix_a), .hsync(hs_a), .vsync(vs_a),
    .blank_n(bn_a), .frame_start(fs_a));

  vga_scanout_reader #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .RD_LATENCY(3)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .fb_rd_addr(addr_b),
    .fb_rd_data(rpb[2]), .pixel_out(pix_b), .hsync(hs_b), .vsync(vs_b),
    .blank_n(bn_b), .frame_start(fs_b));

  vga_scanout_reader #(.RD_LATENCY(1)) u_c (
    .clock(clock), .reset(reset), .enable(enable), .fb_rd_addr(addr_c),
    .fb_rd_data(data_c), .pixel_out(pix_c), .hsync(hs_c), .vsync(vs_c),
    .blank_n(bn_c), .frame_start(fs_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] maddr();
    if (mv >= SVA) return 19'd0;
    if (mh < SHA) return 19'(mv * SHA + mh);
    return 19'(((mv + 1) * SHA) % (SHA * SVA));
  endfunction

  task automatic cmp_out(input string p, input logic [7:0] pix, input logic bn,
                         input logic hs, input logic vs, input logic fs, input exp_t e);
    check({p, "_pix"}, 32'(pix), 32'(e.pix));
    check({p, "_blank_n"}, 32'(bn), 32'(e.bn));
    check({p, "_hsync"}, 32'(hs), 32'(e.hs));
    check({p, "_vsync"}, 32'(vs), 32'(e.vs));
    check({p, "_frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic check_rst();
    check("rst_addr", 32'(addr_a) + 32'(addr_b) + 32'(addr_c), 0);
    check("rst_pix", 32'(pix_a) + 32'(pix_b) + 32'(pix_c), 0);
    check("rst_hsync", 32'({hs_a, hs_b, hs_c}), 7);
    check("rst_vsync", 32'({vs_a, vs_b, vs_c}), 7);
    check("rst_blank_n", 32'({bn_a, bn_b, bn_c}), 0);
    check("rst_frame_start", 32'({fs_a, fs_b, fs_c}), 0);
  endtask

  // One pixel clock: push expectation for the current raster state, retire the oldest
  task automatic cycle();
    exp_t        e, o;
    logic        act, en_s;
    logic [18:0] ma;
    int          k;
    act   = enable && (mh < SHA) && (mv < SVA);
    ma    = maddr();
    e.pix = act ? ramf(ma) : 8'h00;
    e.bn  = act;
    e.hs  = !(enable && mh >= SHA + SHF && mh < SHA + SHF + SHS);
    e.vs  = !(enable && mv >= SVA + SVF && mv < SVA + SVF + SVS);
    e.fs  = enable && mh == 0 && mv == 0;
    check("a_addr", 32'(addr_a), 32'(ma));
    check("b_addr", 32'(addr_b), 32'(ma));
    qa.push_back(e);
    qb.push_back(e);
    if (qa.size() > DA) begin o = qa.pop_front(); cmp_out("a", pix_a, bn_a, hs_a, vs_a, fs_a, o); end
    if (qb.size() > DB) begin o = qb.pop_front(); cmp_out("b", pix_b, bn_b, hs_b, vs_b, fs_b, o); end
    if (c_window) begin
      k = cyc - 2;
      if (cyc < 800) check("c_addr", 32'(addr_c), (cyc < 640) ? 32'(cyc) : 32'd640);
      check("c_hsync", 32'(hs_c), (cyc >= 2 && k % 800 >= 656 && k % 800 <= 751) ? 0 : 1);
      check("c_blank_n", 32'(bn_c), (cyc >= 2 && k % 800 < 640) ? 1 : 0);
      check("c_pix", 32'(pix_c),
            (cyc >= 2 && k % 800 < 640) ? 32'(ramf(19'((k / 800) * 640 + k % 800))) : 0);
      check("c_frame_start", 32'(fs_c), (cyc == 2) ? 1 : 0);
      check("c_vsync", 32'(vs_c), 1);
    end
    en_s = enable;
    @(posedge clock);
    #1;
    if (!en_s) begin
      mh = 0;
      mv = 0;
    end else if (mh == SHT - 1) begin
      mh = 0;
      mv = (mv == SVT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    exp_t idle;
    reset = 1'b0;
    #1;
    check_rst();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check_rst();
    end
    reset = 1'b1;
    mh = 0;
    mv = 0;
    cyc = 0;
    idle.pix = 8'h00; idle.bn = 1'b0; idle.hs = 1'b1; idle.vs = 1'b1; idle.fs = 1'b0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < DA; i++) qa.push_back(idle);
    for (int i = 0; i < DB; i++) qb.push_back(idle);
  endtask

  task automatic run_to(input int v, input int h);
    for (int i = 0; i < 2 * SHT * SVT && !(mv == v && mh == h); i++) cycle();
    check("run_to_pos", 32'(mv * 100 + mh), 32'(v * 100 + h));
  endtask

  initial begin
    #2;
    do_reset(3);
    c_window = 1'b1;
    for (int i = 0; i < 1700; i++) cycle();
    c_window = 1'b0;
    // Abandon a frame mid-line, idle, then restart from the origin
    run_to(2, 7);
    enable = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    enable = 1'b1;
    for (int i = 0; i < 2 * SHT * SVT + 5; i++) cycle();
    // Asynchronous reset in the middle of a frame
    run_to(1, 5);
    do_reset(2);
    for (int i = 0; i < SHT * SVT + 30; i++) cycle();
    // Disabled across reset release, then enabled
    enable = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle();
    enable = 1'b1;
    for (int i = 0; i < SHT * SVT + 10; i++) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
